// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared across the filter-processor pipeline control.
//   state_t   - sequencing states of pipeline_ctrl
//   fwd_sel_t - EXE operand source encodings
//   REG_W     - register-address width
//   CNT_W     - width of the sequencing down-counter
package proc_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_FL   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand-forwarding selects for both EXE operands.
//   ex_ra, ex_rb    in  source registers at the REG/EXE outputs
//   mem_rd, mem_wr  in  EXE/MEM destination and write-enable
//   wb_rd, wb_wr    in  MEM/WB destination and write-enable
//   fwd_a, fwd_b    out operand source (FWD_RF / FWD_MEM / FWD_WB)
module fwd_unit
    import proc_pkg::*;
(
    input  logic [REG_W-1:0] ex_ra,
    input  logic [REG_W-1:0] ex_rb,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // The younger result (EXE/MEM) wins when both stages write the same register.
    always_comb begin
        fwd_a = FWD_RF;
        if (mem_wr && (mem_rd == ex_ra))
            fwd_a = FWD_MEM;
        else if (wb_wr && (wb_rd == ex_ra))
            fwd_a = FWD_WB;
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (mem_wr && (mem_rd == ex_rb))
            fwd_b = FWD_MEM;
        else if (wb_wr && (wb_rd == ex_rb))
            fwd_b = FWD_WB;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard sequencing and forwarding for the filter processor.
//   Parameters: MC_LAT (2..16) multi-cycle EXE occupancy, BR_FLUSH (1..3) branch bubbles.
//   clk, rst                   clock, synchronous active-high reset
//   id_* / ex_* / mem_* / wb_* hazard inputs from the pipeline stages
//   hold_pc, en_if_id, en_reg_exe                 hold controls (1 = hold)
//   flush_if_id, flush_reg_exe, flush_ex_mem      bubble insert on next edge
//   fwd_a, fwd_b               EXE operand source selects
//   mc_done                    final cycle of a multi-cycle op
//   busy                       state is not RUN
//
// state   | meaning
// RUN     | normal flow; branch, multi-cycle and load-use detection active
// BR_FL   | remaining taken-branch bubble cycles, IF/ID and REG/EXE flushed
// MC_WAIT | multi-cycle op occupies EXE; front end frozen until cnt = 0
module pipeline_ctrl
    import proc_pkg::*;
#(
    parameter int MC_LAT   = 4,
    parameter int BR_FLUSH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_Ra,
    input  logic [REG_W-1:0] id_Rb,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] ex_Ra,
    input  logic [REG_W-1:0] ex_Rb,
    input  logic [REG_W-1:0] ex_Rd,
    input  logic             ex_wr,
    input  logic             ex_load,
    input  logic             ex_mc,
    input  logic             ex_br_taken,
    input  logic [REG_W-1:0] mem_Rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_Rd,
    input  logic             wb_wr,
    output logic             hold_pc,
    output logic             en_if_id,
    output logic             en_reg_exe,
    output logic             flush_if_id,
    output logic             flush_reg_exe,
    output logic             flush_ex_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mc_done,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    assign load_use = ex_load & ex_wr &
                      ((id_use_a & (id_Ra == ex_Rd)) | (id_use_b & (id_Rb == ex_Rd)));

    fwd_unit u_fwd (
        .ex_ra  (ex_Ra),
        .ex_rb  (ex_Rb),
        .mem_rd (mem_Rd),
        .mem_wr (mem_wr),
        .wb_rd  (wb_Rd),
        .wb_wr  (wb_wr),
        .fwd_a  (fwd_a_raw),
        .fwd_b  (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;
    assign busy  = !rst && (state != RUN);

    // Mealy outputs; every output is forced low while reset is asserted.
    // A flushed register never has its hold asserted in the same cycle.
    always_comb begin
        hold_pc       = 1'b0;
        en_if_id      = 1'b0;
        en_reg_exe    = 1'b0;
        flush_if_id   = 1'b0;
        flush_reg_exe = 1'b0;
        flush_ex_mem  = 1'b0;
        mc_done       = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_br_taken) begin
                        flush_if_id   = 1'b1;
                        flush_reg_exe = 1'b1;
                    end else if (ex_mc) begin
                        hold_pc      = 1'b1;
                        en_if_id     = 1'b1;
                        en_reg_exe   = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else if (load_use) begin
                        hold_pc       = 1'b1;
                        en_if_id      = 1'b1;
                        flush_reg_exe = 1'b1;
                    end
                end
                BR_FL: begin
                    flush_if_id   = 1'b1;
                    flush_reg_exe = 1'b1;
                end
                MC_WAIT: begin
                    if (cnt != '0) begin
                        hold_pc      = 1'b1;
                        en_if_id     = 1'b1;
                        en_reg_exe   = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else begin
                        mc_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cnt counts the remaining cycles after the current one; the resolve/first
    // cycle is spent in RUN, hence the -2 preload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_br_taken) begin
                        if (BR_FLUSH > 1) begin
                            state <= BR_FL;
                            cnt   <= CNT_W'(BR_FLUSH - 2);
                        end
                    end else if (ex_mc) begin
                        state <= MC_WAIT;
                        cnt   <= CNT_W'(MC_LAT - 2);
                    end
                end
                BR_FL, MC_WAIT: begin
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl.
// u_dut uses MC_LAT=4/BR_FLUSH=2, u_dut2 uses MC_LAT=2/BR_FLUSH=1; both share stimulus.
// Status vectors: {hold_pc,en_if_id,en_reg_exe,flush_if_id,flush_reg_exe,flush_ex_mem,mc_done,busy}
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_Ra, id_Rb, ex_Ra, ex_Rb, ex_Rd, mem_Rd, wb_Rd;
    logic       id_use_a, id_use_b, ex_wr, ex_load, ex_mc, ex_br_taken, mem_wr, wb_wr;

    logic       hold_pc, en_if_id, en_reg_exe, flush_if_id, flush_reg_exe, flush_ex_mem;
    logic       mc_done, busy;
    logic [1:0] fwd_a, fwd_b;
    logic       hold_pc2, en_if_id2, en_reg_exe2, flush_if_id2, flush_reg_exe2, flush_ex_mem2;
    logic       mc_done2, busy2;
    logic [1:0] fwd_a2, fwd_b2;

    logic [7:0] st, st2;
    int         total = 0;
    int         bad   = 0;

    assign st  = {hold_pc, en_if_id, en_reg_exe, flush_if_id, flush_reg_exe, flush_ex_mem, mc_done, busy};
    assign st2 = {hold_pc2, en_if_id2, en_reg_exe2, flush_if_id2, flush_reg_exe2, flush_ex_mem2, mc_done2, busy2};

    always #5 clk = ~clk;

    pipeline_ctrl #(.MC_LAT(4), .BR_FLUSH(2)) u_dut (
        .clk(clk), .rst(rst),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rd(ex_Rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .ex_mc(ex_mc), .ex_br_taken(ex_br_taken),
        .mem_Rd(mem_Rd), .mem_wr(mem_wr), .wb_Rd(wb_Rd), .wb_wr(wb_wr),
        .hold_pc(hold_pc), .en_if_id(en_if_id), .en_reg_exe(en_reg_exe),
        .flush_if_id(flush_if_id), .flush_reg_exe(flush_reg_exe), .flush_ex_mem(flush_ex_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_done(mc_done), .busy(busy)
    );

    pipeline_ctrl #(.MC_LAT(2), .BR_FLUSH(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rd(ex_Rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .ex_mc(ex_mc), .ex_br_taken(ex_br_taken),
        .mem_Rd(mem_Rd), .mem_wr(mem_wr), .wb_Rd(wb_Rd), .wb_wr(wb_wr),
        .hold_pc(hold_pc2), .en_if_id(en_if_id2), .en_reg_exe(en_reg_exe2),
        .flush_if_id(flush_if_id2), .flush_reg_exe(flush_reg_exe2), .flush_ex_mem(flush_ex_mem2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mc_done(mc_done2), .busy(busy2)
    );

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_Ra = 4'd0; id_Rb = 4'd0; id_use_a = 1'b0; id_use_b = 1'b0;
        ex_Ra = 4'd0; ex_Rb = 4'd0; ex_Rd = 4'd0; ex_wr = 1'b0; ex_load = 1'b0;
        ex_mc = 1'b0; ex_br_taken = 1'b0;
        mem_Rd = 4'd0; mem_wr = 1'b0; wb_Rd = 4'd0; wb_wr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset with aggressive inputs: every output must still be 0.
        rst = 1'b1;
        ex_mc = 1'b1; ex_br_taken = 1'b1; ex_load = 1'b1; ex_wr = 1'b1;
        ex_Rd = 4'd5; id_Ra = 4'd5; id_use_a = 1'b1;
        ex_Ra = 4'd3; ex_Rb = 4'd3; mem_Rd = 4'd3; mem_wr = 1'b1;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_outputs: got %b want %b", st, 8'h00); end
        total++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            bad++; $display("FAIL reset_fwd: got a=%b b=%b want 00/00", fwd_a, fwd_b);
        end
        tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_idle: got %b want %b", st, 8'h00); end

        // Enter MC_WAIT, then reset while cnt=1 (third cycle of the op).
        ex_mc = 1'b1;
        tick();
        tick();
        #1;
        total++;
        if (st !== 8'b1110_0101) begin bad++; $display("FAIL reset_mc_pre: got %b want %b", st, 8'b1110_0101); end
        ex_mc = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_mid_mc: got %b want %b", st, 8'h00); end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_mc_abort: got %b want %b (no mc_done, RUN)", st, 8'h00); end
        tick();
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_mc_after: got %b want %b", st, 8'h00); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_load = 1'b1; ex_wr = 1'b1; ex_Rd = 4'd5; id_Ra = 4'd5; id_use_a = 1'b1;
        #1;
        total++;
        if (st !== 8'b1100_1000) begin bad++; $display("FAIL load_use_stall: got %b want %b", st, 8'b1100_1000); end
        tick();
        ex_load = 1'b0; ex_wr = 1'b0;   // bubble now in EXE
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL load_use_clear: got %b want %b", st, 8'h00); end
        ex_load = 1'b1; ex_wr = 1'b1; id_use_a = 1'b0;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL load_use_unused: got %b want %b", st, 8'h00); end
        id_Rb = 4'd5; id_use_b = 1'b1;
        #1;
        total++;
        if (st !== 8'b1100_1000) begin bad++; $display("FAIL load_use_rb: got %b want %b", st, 8'b1100_1000); end
        ex_load = 1'b0;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL load_use_noload: got %b want %b", st, 8'h00); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        ex_br_taken = 1'b1;
        #1;
        total++;
        if (st !== 8'b0001_1000) begin bad++; $display("FAIL br_cycle0: got %b want %b", st, 8'b0001_1000); end
        total++;
        if (st2 !== 8'b0001_1000) begin bad++; $display("FAIL br1_cycle0: got %b want %b", st2, 8'b0001_1000); end
        tick();
        ex_br_taken = 1'b0;
        #1;
        total++;
        if (st !== 8'b0001_1001) begin bad++; $display("FAIL br_cycle1: got %b want %b", st, 8'b0001_1001); end
        total++;
        if (st2 !== 8'h00) begin bad++; $display("FAIL br1_cycle1: got %b want %b", st2, 8'h00); end
        tick();
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL br_cycle2: got %b want %b", st, 8'h00); end
    endtask

    task automatic test_mc();
        logic [7:0] exp4 [5];
        logic [7:0] exp2 [3];
        exp4 = '{8'b1110_0100, 8'b1110_0101, 8'b1110_0101, 8'b0000_0011, 8'h00};
        exp2 = '{8'b1110_0100, 8'b0000_0011, 8'h00};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            ex_mc = (i < 4);
            #1;
            total++;
            if (st !== exp4[i]) begin bad++; $display("FAIL mc4_cycle%0d: got %b want %b", i, st, exp4[i]); end
            tick();
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            ex_mc = (i < 2);
            #1;
            total++;
            if (st2 !== exp2[i]) begin bad++; $display("FAIL mc2_cycle%0d: got %b want %b", i, st2, exp2[i]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        ex_br_taken = 1'b1; ex_mc = 1'b1;
        ex_load = 1'b1; ex_wr = 1'b1; ex_Rd = 4'd7; id_Ra = 4'd7; id_use_a = 1'b1;
        #1;
        total++;
        if (st !== 8'b0001_1000) begin bad++; $display("FAIL prio_cycle0: got %b want %b", st, 8'b0001_1000); end
        tick();
        ex_br_taken = 1'b0;   // ex_mc and load-use still presented, ignored in BR_FL
        #1;
        total++;
        if (st !== 8'b0001_1001) begin bad++; $display("FAIL prio_cycle1: got %b want %b", st, 8'b0001_1001); end
        tick();
        clear_inputs();
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL prio_cycle2: got %b want %b", st, 8'h00); end
    endtask

    task automatic test_fwd();
        ex_Ra = 4'd3; ex_Rb = 4'd9;
        mem_Rd = 4'd3; mem_wr = 1'b1; wb_Rd = 4'd3; wb_wr = 1'b1;
        #1;
        total++;
        if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_a_both: got %b want 01", fwd_a); end
        total++;
        if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_none: got %b want 00", fwd_b); end
        mem_wr = 1'b0;
        #1;
        total++;
        if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_a_wb: got %b want 10", fwd_a); end
        wb_wr = 1'b0;
        #1;
        total++;
        if (fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_a_rf: got %b want 00", fwd_a); end
        // Operand b: R0 is an ordinary register; a enabled write to another register does not match.
        ex_Rb = 4'd0; wb_Rd = 4'd0; wb_wr = 1'b1; mem_Rd = 4'd9; mem_wr = 1'b1;
        #1;
        total++;
        if (fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_b_r0_wb: got %b want 10", fwd_b); end
        ex_Rb = 4'd9;
        #1;
        total++;
        if (fwd_b !== 2'b01) begin bad++; $display("FAIL fwd_b_mem: got %b want 01", fwd_b); end
        total++;
        if (fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_a_nomatch: got %b want 00", fwd_a); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mc();
        test_priority();
        test_fwd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
